cos_range_reduce: RTL and testbench
===================================

Name: cos_range_reduce

Overview:
- Upstream argument-conditioning stage for the cos(x) Taylor-series unit.
- Accepts an arbitrary unsigned angle in radians, reduces it modulo 2π, and folds it into [0, π/2].
- Emits the 10-bit Q2.8 argument that the cos unit consumes, plus a negate flag so downstream logic can restore the sign of cos.
- Iterative: one 2π subtraction per cycle, with a start/done handshake matching the cos unit.

Parameters:
- ANG_W, 16, input angle width (unsigned Q(ANG_W-8).8)
- HALF_PI, 402, π/2 in Q.8 (0x192)
- PI_C, 804, π in Q.8
- TWO_PI, 1608, 2π in Q.8

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  request; sampled only in IDLE
- angle  in  ANG_W  unsigned angle, Q.8 radians; captured on the accepting edge
- x_out  out  10  folded argument, Q2.8, range 0..402
- negate  out  1  1 = downstream must negate cos(x_out)
- busy  out  1  high in REDUCE, FOLD and DONE
- done  out  1  one-cycle pulse; x_out/negate valid from this cycle on

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; r=0; x_out=0, negate=0, busy=0, done=0.
  - Reset mid-operation aborts immediately. No done is issued for the aborted request.
- States: IDLE, REDUCE, FOLD, DONE. State, r, x_out and negate are all registered. done and busy are Moore outputs decoded from state.
- IDLE:
  - If start=1 at a rising edge: r<=angle, go to REDUCE.
  - Otherwise hold. x_out/negate keep their last values.
- REDUCE:
  - If r >= TWO_PI: r<=r-TWO_PI, stay in REDUCE.
  - Else go to FOLD.
  - Comparison and subtraction are unsigned, ANG_W bits wide; no underflow is possible.
- FOLD (one cycle), registering on the exit edge:
  - r <= HALF_PI: x_out=r, negate=0
  - r <= PI_C: x_out=PI_C-r, negate=1
  - r < PI_C+HALF_PI: x_out=r-PI_C, negate=1
  - else: x_out=TWO_PI-r, negate=0
  - Then go to DONE. Result width is truncated to 10 bits; the value is always ≤ 402.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency, with edge 0 as the accepting edge and N = floor(angle/TWO_PI):
  - Subtractions occur at edges 1..N.
  - REDUCE→FOLD at edge N+1.
  - x_out/negate update and done rises at edge N+2; done falls at edge N+3.
  - Worst case for ANG_W=16: N=40.
- start while busy=1 is ignored, not queued.
- start held high continuously: a new request is accepted on the first IDLE edge after DONE, i.e. back-to-back operation with one IDLE cycle between requests.
- angle changes after the accepting edge have no effect.
- Boundaries:
  - r=HALF_PI gives x_out=402, negate=0.
  - r=PI_C gives x_out=0, negate=1.
  - r=PI_C+HALF_PI gives x_out=402, negate=0.
  - angle=TWO_PI gives N=1, x_out=0, negate=0.

Test Plan:
- angle=268 (π/3), start pulse -> N=0; done at edge 2; x_out=268 (0b0100001100), negate=0.
- angle=1876 (2π+π/3) -> exactly one subtraction; done at edge 3; x_out=268, negate=0.
- angle=804, then angle=1000, then angle=1608, each run separately:
  - 804 -> x_out=0, negate=1
  - 1000 -> x_out=196, negate=1
  - 1608 -> x_out=0, negate=0, done at edge 3
- angle=0xFFFF -> 40 subtractions, done at edge 42; x_out=393, negate=0. A start pulse injected at edge 10 is ignored: only one done pulse occurs.
- Reset and handshake checks:
  - Drop rst to 0 mid-REDUCE (angle=0xFFFF, at edge 20) -> all outputs 0 immediately, no done pulse.
  - After release, angle=402 -> x_out=402, negate=0, done at edge 2.
  - start held high across two requests -> exactly two done pulses, separated by one IDLE cycle.

Source files
------------

// File: rtl/cos_range_reduce.sv
// Argument conditioning for the cos(x) Taylor unit: reduces an unsigned Q.8 angle
// modulo 2*pi, one subtraction per cycle, then folds it into [0, pi/2] with a sign flag.
module cos_range_reduce #(
    parameter int ANG_W   = 16,
    parameter int HALF_PI = 402,
    parameter int PI_C    = 804,
    parameter int TWO_PI  = 1608
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ANG_W-1:0] angle,
    output logic [9:0]       x_out,
    output logic             negate,
    output logic             busy,
    output logic             done
);

    // state    | meaning
    // S_IDLE   | waiting for start; x_out/negate hold the last result
    // S_REDUCE | subtract 2*pi from r while r >= 2*pi
    // S_FOLD   | r in [0, 2*pi): fold into [0, pi/2], register result
    // S_DONE   | one-cycle done pulse
    typedef enum logic [1:0] {
        S_IDLE,
        S_REDUCE,
        S_FOLD,
        S_DONE
    } state_t;

    localparam logic [ANG_W-1:0] K_HALF   = ANG_W'(HALF_PI);
    localparam logic [ANG_W-1:0] K_PI     = ANG_W'(PI_C);
    localparam logic [ANG_W-1:0] K_3HALF  = ANG_W'(PI_C + HALF_PI);
    localparam logic [ANG_W-1:0] K_TWO_PI = ANG_W'(TWO_PI);

    state_t           state_q, state_d;
    logic [ANG_W-1:0] r_q, r_d;
    logic [9:0]       x_q, x_d;
    logic             neg_q, neg_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            x_q     <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            x_q     <= x_d;
            neg_q   <= neg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        x_d     = x_q;
        neg_d   = neg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    r_d     = angle;
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (r_q >= K_TWO_PI) begin
                    r_d = r_q - K_TWO_PI;
                end else begin
                    state_d = S_FOLD;
                end
            end
            S_FOLD: begin
                // r < 2*pi here, so every difference below is non-negative and <= pi/2
                if (r_q <= K_HALF) begin
                    x_d   = 10'(r_q);
                    neg_d = 1'b0;
                end else if (r_q <= K_PI) begin
                    x_d   = 10'(K_PI - r_q);
                    neg_d = 1'b1;
                end else if (r_q < K_3HALF) begin
                    x_d   = 10'(r_q - K_PI);
                    neg_d = 1'b1;
                end else begin
                    x_d   = 10'(K_TWO_PI - r_q);
                    neg_d = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign x_out  = x_q;
    assign negate = neg_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_cos_range_reduce.sv
// Bench for cos_range_reduce: vector table plus handshake/reset sequences, with a
// scoreboard of expected results checked on each done pulse (value and latency).
module tb_cos_range_reduce;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] angle;
    logic [9:0]  x_out;
    logic        negate;
    logic        busy;
    logic        done;

    cos_range_reduce dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .angle  (angle),
        .x_out  (x_out),
        .negate (negate),
        .busy   (busy),
        .done   (done)
    );

    typedef struct {
        logic [15:0] ang;
        logic [9:0]  x;
        logic        neg;
        int          lat;
    } vec_t;

    typedef struct {
        logic [9:0] x;
        logic       neg;
        int         acc;
        int         lat;
        string      name;
    } exp_t;

    vec_t vecs[15];
    exp_t sb[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   done_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done=1 at edge %0d, required 0", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_x"},   int'(x_out),  int'(e.x));
                chk({e.name, "_neg"}, int'(negate), int'(e.neg));
                chk({e.name, "_lat"}, cyc - e.acc,  e.lat);
            end
        end
    end

    task automatic drain(input string nm);
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: %0d results outstanding, required 0", nm, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_req(input logic [15:0] a, input logic [9:0] x, input logic ng,
                           input int lat, input string nm);
        int acc;
        @(negedge clk);
        angle = a;
        start = 1'b1;
        acc   = cyc + 1;
        sb.push_back('{x: x, neg: ng, acc: acc, lat: lat, name: nm});
        @(negedge clk);
        start = 1'b0;
        angle = 16'($urandom);
        chk({nm, "_busy"}, int'(busy), 1);
        drain(nm);
    endtask

    initial begin
        int acc;
        int dc0;
        n_cmp = 0;
        n_bad = 0;
        done_cnt = 0;
        start = 1'b0;
        angle = '0;
        rst = 1'b1;

        vecs[0]  = '{16'd268,   10'd268, 1'b0, 2};
        vecs[1]  = '{16'd1876,  10'd268, 1'b0, 3};
        vecs[2]  = '{16'd804,   10'd0,   1'b1, 2};
        vecs[3]  = '{16'd1000,  10'd196, 1'b1, 2};
        vecs[4]  = '{16'd1608,  10'd0,   1'b0, 3};
        vecs[5]  = '{16'd402,   10'd402, 1'b0, 2};
        vecs[6]  = '{16'd1206,  10'd402, 1'b0, 2};
        vecs[7]  = '{16'd403,   10'd401, 1'b1, 2};
        vecs[8]  = '{16'd0,     10'd0,   1'b0, 2};
        vecs[9]  = '{16'd500,   10'd304, 1'b1, 2};
        vecs[10] = '{16'd1100,  10'd296, 1'b1, 2};
        vecs[11] = '{16'd1500,  10'd108, 1'b0, 2};
        vecs[12] = '{16'd4021,  10'd1,   1'b1, 4};
        vecs[13] = '{16'd1205,  10'd401, 1'b1, 2};
        vecs[14] = '{16'hFFFF,  10'd393, 1'b0, 42};

        #1 rst = 1'b0;
        #2;
        chk("rst_x",    int'(x_out),  0);
        chk("rst_neg",  int'(negate), 0);
        chk("rst_busy", int'(busy),   0);
        chk("rst_done", int'(done),   0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_req(vecs[i].ang, vecs[i].x, vecs[i].neg, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // start pulse mid-reduction must be ignored
        @(negedge clk);
        angle = 16'hFFFF;
        start = 1'b1;
        acc   = cyc + 1;
        sb.push_back('{x: 10'd393, neg: 1'b0, acc: acc, lat: 42, name: "ignore_start"});
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        angle = 16'd268;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignore_start_busy", int'(busy), 1);
        drain("ignore_start");

        // reset mid-REDUCE aborts with no done
        @(negedge clk);
        angle = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_x",    int'(x_out),  0);
        chk("abort_neg",  int'(negate), 0);
        chk("abort_busy", int'(busy),   0);
        chk("abort_done", int'(done),   0);
        dc0 = done_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_no_done", done_cnt - dc0, 0);
        chk("abort_idle_busy", int'(busy), 0);

        run_req(16'd402, 10'd402, 1'b0, 2, "post_rst");

        // start held high: two requests, one IDLE cycle between them
        dc0 = done_cnt;
        @(negedge clk);
        angle = 16'd268;
        start = 1'b1;
        acc   = cyc + 1;
        sb.push_back('{x: 10'd268, neg: 1'b0, acc: acc,     lat: 2, name: "held1"});
        sb.push_back('{x: 10'd268, neg: 1'b0, acc: acc + 4, lat: 2, name: "held2"});
        repeat (5) @(negedge clk);
        start = 1'b0;
        drain("held");
        repeat (5) @(negedge clk);
        chk("held_done_count", done_cnt - dc0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
